// File: rtl/mod_mul_il.sv
// mod_mul_il: bit-serial interleaved modular multiplier, y = (a*b) mod m.
// Optional busy output when MOD_MUL_IL_BUSY_EN is defined.
module mod_mul_il #(
    parameter int NBITS = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p
`ifdef MOD_MUL_IL_BUSY_EN
    ,
    output logic             busy
`endif
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int XW = NBITS + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [NBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [NBITS-1:0] m_reg;
    logic [XW-1:0]    r;
    logic [IW-1:0]    idx;

    logic [XW-1:0]    m_x;
    logic [XW-1:0]    addend;
    logic [XW-1:0]    t0;
    logic [XW-1:0]    t1;
    logic [XW-1:0]    t2;

    // One interleaved step: double, add a if the b bit is set, reduce twice
    always_comb begin
        m_x    = {2'b00, m_reg};
        addend = b_reg[idx] ? {2'b00, a_reg} : '0;
        t0     = (r << 1) + addend;
        t1     = (t0 >= m_x) ? (t0 - m_x) : t0;
        t2     = (t1 >= m_x) ? (t1 - m_x) : t1;
    end

    // Control and datapath registers; enable_p is only looked at in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            r          <= '0;
            idx        <= '0;
            y          <= '0;
            done_irq_p <= 1'b0;
        end else begin
            done_irq_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_p) begin
                        a_reg <= a;
                        b_reg <= b;
                        m_reg <= m;
                        r     <= '0;
                        idx   <= IW'(NBITS - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    r <= t2;
                    if (idx == '0) begin
                        y          <= t2[NBITS-1:0];
                        done_irq_p <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOD_MUL_IL_BUSY_EN
    // Busy mirrors the registered RUN state
    assign busy = (state == RUN);
`endif

endmodule

// File: tb/tb_mod_mul_il.sv
// tb_mod_mul_il: directed vectors for mod_mul_il at NBITS=16 and NBITS=2048.
// Define MOD_MUL_IL_BUSY_EN to also check the busy output.
module tb_mod_mul_il;

    localparam int N  = 16;
    localparam int NB = 2048;

    logic          clk;
    logic          rst_n;
    logic          enable_p;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  m;
    logic [N-1:0]  y;
    logic          done_irq_p;

    logic          en_big;
    logic [NB-1:0] a_big;
    logic [NB-1:0] b_big;
    logic [NB-1:0] m_big;
    logic [NB-1:0] y_big;
    logic          done_big;

`ifdef MOD_MUL_IL_BUSY_EN
    logic          busy;
    logic          busy_big;
`endif

    int n_vec;
    int n_err;

    mod_mul_il #(.NBITS(N)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_p   (enable_p),
        .a          (a),
        .b          (b),
        .m          (m),
        .y          (y),
        .done_irq_p (done_irq_p)
`ifdef MOD_MUL_IL_BUSY_EN
        ,
        .busy       (busy)
`endif
    );

    mod_mul_il #(.NBITS(NB)) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_p   (en_big),
        .a          (a_big),
        .b          (b_big),
        .m          (m_big),
        .y          (y_big),
        .done_irq_p (done_big)
`ifdef MOD_MUL_IL_BUSY_EN
        ,
        .busy       (busy_big)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse enable_p for one capture edge, then scramble the inputs
    task automatic start(input string tag, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic [N-1:0] mv);
        enable_p = 1'b1;
        a = av;
        b = bv;
        m = mv;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        a = 16'hA5A5;
        b = 16'h5A5A;
        m = 16'h0001;
        check({tag, "_done_low"}, {63'd0, done_irq_p}, 64'd0);
    endtask

    // Wait for done; optionally poke enable_p once mid-run
    task automatic wait_done(input int inj, output int lat, output int bc);
        lat = 0;
        bc = 0;
`ifdef MOD_MUL_IL_BUSY_EN
        bc = int'(busy);
`endif
        while (!done_irq_p && lat < 40) begin
            if (lat == inj) begin
                enable_p = 1'b1;
                a = 16'd1;
                b = 16'd1;
                m = 16'd3;
            end else begin
                enable_p = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
`ifdef MOD_MUL_IL_BUSY_EN
            bc += int'(busy);
`endif
        end
        enable_p = 1'b0;
    endtask

    task automatic run(input string tag, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input logic [N-1:0] mv,
                       input logic [N-1:0] exp, input int inj);
        int lat;
        int bc;
        start(tag, av, bv, mv);
        wait_done(inj, lat, bc);
        check({tag, "_lat"}, 64'(lat), 64'(N));
        check({tag, "_y"}, {48'd0, y}, {48'd0, exp});
`ifdef MOD_MUL_IL_BUSY_EN
        check({tag, "_busy"}, 64'(bc), 64'(N));
`endif
    endtask

    initial begin
        int lat;
        int pulses;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        enable_p = 1'b0;
        a = '0;
        b = '0;
        m = '0;
        en_big = 1'b0;
        a_big = '0;
        b_big = '0;
        m_big = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", {48'd0, y}, 64'd0);
        check("rst_done", {63'd0, done_irq_p}, 64'd0);
`ifdef MOD_MUL_IL_BUSY_EN
        check("rst_busy", {63'd0, busy}, 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-width operation
        en_big = 1'b1;
        a_big = NB'(1093);
        b_big = NB'(1999);
        m_big = NB'(2013);
        @(posedge clk);
        #1;
        en_big = 1'b0;
        a_big = '1;
        lat = 0;
        while (!done_big && lat < 2100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("big_lat", 64'(lat), 64'(NB));
        check("big_y", y_big[63:0], 64'd802);
        check("big_hi", {63'd0, |y_big[NB-1:64]}, 64'd0);
        @(posedge clk);
        #1;
        check("big_done_fall", {63'd0, done_big}, 64'd0);

        // Directed 16-bit vectors, each started in the done cycle of the last
        run("v_5x1", 16'd5, 16'd1, 16'd7, 16'd5, -1);
        run("v_12x12", 16'd12, 16'd12, 16'd13, 16'd1, -1);
        run("v_0xffff", 16'd0, 16'hFFFF, 16'd13, 16'd0, -1);
        run("v_3xffff", 16'd3, 16'hFFFF, 16'd1000, 16'd605, -1);
        run("v_maxm", 16'hFFFE, 16'd2, 16'hFFFF, 16'd65533, -1);
        run("v_bm", 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'd0, -1);
        run("v_mid_en", 16'd1093, 16'd1999, 16'd2013, 16'd802, 5);

        // Exactly one done pulse: none in the following cycles
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            pulses += int'(done_irq_p);
        end
        check("single_pulse", 64'(pulses), 64'd0);

        // Abort mid-run
        start("abort", 16'd6, 16'd6, 16'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_y", {48'd0, y}, 64'd0);
        check("abort_done", {63'd0, done_irq_p}, 64'd0);
`ifdef MOD_MUL_IL_BUSY_EN
        check("abort_busy", {63'd0, busy}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            pulses += int'(done_irq_p);
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        check("abort_y_hold", {48'd0, y}, 64'd0);

        run("v_after", 16'd6, 16'd6, 16'd7, 16'd1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
